// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter
//   Shares one Wishbone-classic memory port between the instruction-fetch
//   master (m0) and the data master (m1). Round-robin arbitration with a
//   registered one-cycle decision. The grant is held for the owner's whole
//   cyc. A slave watchdog turns a hung strobe into a one-cycle err pulse.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   mX_cyc_i/stb_i/we_i    master X cycle, strobe, write enable   (X = 0,1)
//   mX_sel_i/addr_i/data_i master X byte selects, address, write data
//   mX_data_o/ack_o/err_o  master X read data, acknowledge, watchdog error
//   s_cyc_o/stb_o/we_o     slave cycle, strobe, write enable
//   s_sel_o/addr_o/data_o  slave byte selects, address, write data
//   s_data_i/ack_i         slave read data, acknowledge
//   grant_o                one-hot current owner (01 = m0, 10 = m1, 00 = none)
//   timeout_o              sticky timeout flag
//   timeout_clr_i          clears timeout_o (a new timeout in the same cycle wins)
module wb_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // master 0 (instruction fetch)
  input  logic                      m0_cyc_i,
  input  logic                      m0_stb_i,
  input  logic                      m0_we_i,
  input  logic [DATA_WIDTH/8-1:0]   m0_sel_i,
  input  logic [ADDR_WIDTH-1:0]     m0_addr_i,
  input  logic [DATA_WIDTH-1:0]     m0_data_i,
  output logic [DATA_WIDTH-1:0]     m0_data_o,
  output logic                      m0_ack_o,
  output logic                      m0_err_o,
  // master 1 (data)
  input  logic                      m1_cyc_i,
  input  logic                      m1_stb_i,
  input  logic                      m1_we_i,
  input  logic [DATA_WIDTH/8-1:0]   m1_sel_i,
  input  logic [ADDR_WIDTH-1:0]     m1_addr_i,
  input  logic [DATA_WIDTH-1:0]     m1_data_i,
  output logic [DATA_WIDTH-1:0]     m1_data_o,
  output logic                      m1_ack_o,
  output logic                      m1_err_o,
  // shared slave port
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [DATA_WIDTH/8-1:0]   s_sel_o,
  output logic [ADDR_WIDTH-1:0]     s_addr_o,
  output logic [DATA_WIDTH-1:0]     s_data_o,
  input  logic [DATA_WIDTH-1:0]     s_data_i,
  input  logic                      s_ack_i,
  // status
  output logic [1:0]                grant_o,
  output logic                      timeout_o,
  input  logic                      timeout_clr_i
);

  localparam bit          WD_EN = (TIMEOUT_CYCLES != 0);
  localparam int unsigned WDW   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LIMIT = (TIMEOUT_CYCLES == 0) ? '0 : WDW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic           last_q, last_d;       // 0 = m0 granted last, 1 = m1
  logic           err_own_q, err_own_d; // owner that timed out
  logic           err_q, err_d;         // one-cycle err pulse
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           timeout_q, timeout_d;

  // Owner index of the current grant (or of the timed-out owner in ERR).
  logic own_idx, own_cyc, oth_cyc, own_stb, stall, wd_fire;

  always_comb begin
    own_idx = (state_q == ST_ERR) ? err_own_q : (state_q == ST_GNT1);
    own_cyc = own_idx ? m1_cyc_i : m0_cyc_i;
    oth_cyc = own_idx ? m0_cyc_i : m1_cyc_i;
    own_stb = own_idx ? m1_stb_i : m0_stb_i;
    stall   = own_stb & ~s_ack_i;
    wd_fire = WD_EN & stall & (wdog_q == WD_LIMIT);
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    err_own_d = err_own_q;
    err_d     = 1'b0;
    wdog_d    = '0;
    timeout_d = timeout_clr_i ? 1'b0 : timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          // Tie: the master that was not granted last wins.
          state_d = last_q ? ST_GNT0 : ST_GNT1;
          last_d  = ~last_q;
        end else if (m0_cyc_i) begin
          state_d = ST_GNT0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = ST_GNT1;
          last_d  = 1'b1;
        end
      end

      ST_GNT0, ST_GNT1: begin
        if (!own_cyc) begin
          // Hand straight over to a waiting master without an IDLE bubble.
          if (oth_cyc) begin
            state_d = own_idx ? ST_GNT0 : ST_GNT1;
            last_d  = ~own_idx;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (wd_fire) begin
          state_d   = ST_ERR;
          err_own_d = own_idx;
          err_d     = 1'b1;
          timeout_d = 1'b1;
        end else if (WD_EN && stall) begin
          wdog_d = wdog_q + WDW'(1);
        end
      end

      ST_ERR: begin
        if (!own_cyc) begin
          if (oth_cyc) begin
            state_d = own_idx ? ST_GNT0 : ST_GNT1;
            last_d  = ~own_idx;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      err_own_q <= 1'b0;
      err_q     <= 1'b0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      err_own_q <= err_own_d;
      err_q     <= err_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  // Datapath routing follows the registered state, so an asynchronous reset
  // drops the slave cycle immediately.
  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_addr_o  = '0;
    s_data_o  = '0;
    m0_ack_o  = 1'b0;
    m0_data_o = '0;
    m1_ack_o  = 1'b0;
    m1_data_o = '0;
    unique case (state_q)
      ST_GNT0: begin
        s_cyc_o   = m0_cyc_i;
        s_stb_o   = m0_stb_i;
        s_we_o    = m0_we_i;
        s_sel_o   = m0_sel_i;
        s_addr_o  = m0_addr_i;
        s_data_o  = m0_data_i;
        m0_ack_o  = s_ack_i;
        m0_data_o = s_data_i;
      end
      ST_GNT1: begin
        s_cyc_o   = m1_cyc_i;
        s_stb_o   = m1_stb_i;
        s_we_o    = m1_we_i;
        s_sel_o   = m1_sel_i;
        s_addr_o  = m1_addr_i;
        s_data_o  = m1_data_i;
        m1_ack_o  = s_ack_i;
        m1_data_o = s_data_i;
      end
      default: ;
    endcase
  end

  assign grant_o   = {state_q == ST_GNT1, state_q == ST_GNT0};
  assign m0_err_o  = err_q & ~err_own_q;
  assign m1_err_o  = err_q & err_own_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
module tb_wb_mem_arbiter;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = DW / 8;
  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]             cyc, stb, we, ack, err;
  logic [1:0][SW-1:0]     sel;
  logic [1:0][AW-1:0]     addr;
  logic [1:0][DW-1:0]     wdat, rdat;
  logic                   s_cyc, s_stb, s_we, s_ack, tmo_o, tmo_clr;
  logic [SW-1:0]          s_sel;
  logic [AW-1:0]          s_addr;
  logic [DW-1:0]          s_wdat, s_rdat;
  logic [1:0]             grant;

  wb_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
    .m0_addr_i(addr[0]), .m0_data_i(wdat[0]), .m0_data_o(rdat[0]),
    .m0_ack_o(ack[0]), .m0_err_o(err[0]),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
    .m1_addr_i(addr[1]), .m1_data_i(wdat[1]), .m1_data_o(rdat[1]),
    .m1_ack_o(ack[1]), .m1_err_o(err[1]),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_addr_o(s_addr), .s_data_o(s_wdat), .s_data_i(s_rdat), .s_ack_i(s_ack),
    .grant_o(grant), .timeout_o(tmo_o), .timeout_clr_i(tmo_clr)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who owns the port, whether the owner timed out,
  // and how many consecutive stalled strobes it has accumulated.
  int owner;     // -1 = nobody
  bit in_err;
  int eown;
  int stall;
  int last;
  bit epulse;
  bit tmo_m;
  logic [1:0] exp_ack, exp_err;

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1; in_err = 0; eown = 0; stall = 0; last = 1; epulse = 0; tmo_m = 0;
  endtask

  task automatic grab(input int x);
    owner = x; last = x; stall = 0;
  endtask

  task automatic handoff(input int x);
    in_err = 0; stall = 0;
    if (cyc[1-x]) grab(1 - x);
    else owner = -1;
  endtask

  task automatic model_next();
    bit fire;
    fire = 0;
    if (in_err) begin
      if (!cyc[eown]) handoff(eown);
    end else if (owner < 0) begin
      if (cyc[0] && cyc[1]) grab(1 - last);
      else if (cyc[0]) grab(0);
      else if (cyc[1]) grab(1);
    end else if (!cyc[owner]) begin
      handoff(owner);
    end else if (stb[owner] && !s_ack) begin
      stall++;
      if (stall == TMO) begin
        fire = 1; in_err = 1; eown = owner; owner = -1; stall = 0;
      end
    end else begin
      stall = 0;
    end
    epulse = fire;
    if (fire) tmo_m = 1;
    else if (tmo_clr) tmo_m = 0;
  endtask

  task automatic check_all();
    int o;
    logic [1:0] ge;
    logic [1:0][DW-1:0] de;
    logic ec, es, ew;
    logic [SW-1:0] esel;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    o = (owner >= 0 && !in_err) ? owner : -1;
    ge = '0; de = '0; exp_ack = '0; exp_err = '0;
    ec = 0; es = 0; ew = 0; esel = '0; ea = '0; ed = '0;
    if (o >= 0) begin
      ge[o] = 1'b1; exp_ack[o] = s_ack; de[o] = s_rdat;
      ec = cyc[o]; es = stb[o]; ew = we[o]; esel = sel[o]; ea = addr[o]; ed = wdat[o];
    end
    if (epulse) exp_err[eown] = 1'b1;
    cmp("grant", grant, ge);
    cmp("s_cyc", s_cyc, ec);
    cmp("s_stb", s_stb, es);
    cmp("s_we", s_we, ew);
    cmp("s_sel", s_sel, esel);
    cmp("s_addr", s_addr, ea);
    cmp("s_data", s_wdat, ed);
    cmp("ack", ack, exp_ack);
    cmp("err", err, exp_err);
    cmp("m0_data", rdat[0], de[0]);
    cmp("m1_data", rdat[1], de[1]);
    cmp("timeout", tmo_o, tmo_m);
  endtask

  task automatic settle();
    #1;
    check_all();
  endtask

  task automatic adv();
    model_next();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    cyc = '0; stb = '0; we = '0; sel = '0; addr = '0; wdat = '0;
    s_ack = 0; s_rdat = '0; tmo_clr = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    model_reset();
    settle();
    @(posedge clk);
    #2;
    rst_n = 1;
  endtask

  task automatic new_beat(input int i);
    stb[i] = 1'b1;
    we[i] = 1'($urandom_range(1));
    sel[i] = SW'($urandom);
    addr[i] = $urandom;
    wdat[i] = $urandom;
  endtask

  int n0, n1, err_at, err_cnt, hang_left;

  initial begin
    clear_inputs();
    model_reset();
    exp_ack = '0; exp_err = '0;

    // Reset state
    do_reset();
    cmp("rst_grant", grant, 2'b00);
    cmp("rst_timeout", tmo_o, 1'b0);

    // m0 single read
    cyc[0] = 1; stb[0] = 1; we[0] = 0; sel[0] = '1; addr[0] = 32'h0000_0100;
    settle(); cmp("rd_arb_latency", grant, 2'b00); adv();
    settle(); cmp("rd_grant", grant, 2'b01); adv();
    s_ack = 1; s_rdat = 32'h1234_5678;
    settle(); cmp("rd_ack", ack[0], 1'b1); cmp("rd_data", rdat[0], 32'h1234_5678); adv();
    s_ack = 0; s_rdat = '0; cyc[0] = 0; stb[0] = 0;
    settle(); adv();
    settle(); cmp("rd_idle", grant, 2'b00); adv();

    // Tie after reset: m0 first, then m1 without an IDLE bubble
    do_reset();
    cyc = 2'b11; stb = 2'b11;
    settle(); adv();
    settle(); cmp("tie_first", grant, 2'b01);
    s_ack = 1; adv();
    s_ack = 0; cyc[0] = 0; stb[0] = 0;
    settle(); adv();
    settle(); cmp("tie_handoff", grant, 2'b10); adv();

    // m0 holds cyc for 4 beats while m1 waits
    do_reset();
    cyc[0] = 1; new_beat(0);
    settle(); adv();
    cyc[1] = 1; new_beat(1);
    n0 = 0; n1 = 0;
    for (int b = 0; b < 4; b++) begin
      s_ack = 0; settle(); adv();
      s_ack = 1; settle();
      if (ack[0]) n0++;
      if (ack[1]) n1++;
      adv();
      new_beat(0);
    end
    cmp("burst_m0_acks", n0, 4);
    cmp("burst_m1_acks", n1, 0);
    s_ack = 0; cyc[0] = 0; stb[0] = 0;
    settle(); adv();
    settle(); cmp("burst_handoff", grant, 2'b10); adv();
    cyc[1] = 0; stb[1] = 0;
    settle(); adv();

    // Watchdog timeout on m1, late ack ignored
    do_reset();
    cyc[1] = 1; new_beat(1);
    settle(); adv();
    err_at = -1; err_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (err_at >= 0 && k == err_at + 1) s_ack = 1;
      if (err_at >= 0 && k == err_at + 3) begin cyc[1] = 0; stb[1] = 0; s_ack = 0; end
      settle();
      if (err[1]) begin
        err_cnt++;
        if (err_at < 0) begin
          err_at = k;
          cmp("tmo_s_cyc", s_cyc, 1'b0);
          cmp("tmo_flag_set", tmo_o, 1'b1);
        end
      end
      if (err_at >= 0 && k > err_at) cmp("tmo_late_ack", ack[1], 1'b0);
      adv();
    end
    cmp("tmo_cycle", err_at, 8);
    cmp("tmo_pulse_count", err_cnt, 1);
    settle(); cmp("tmo_sticky", tmo_o, 1'b1);
    tmo_clr = 1; adv();
    tmo_clr = 0;
    settle(); cmp("tmo_cleared", tmo_o, 1'b0); adv();

    // Asynchronous reset during GNT1 with strobe high
    do_reset();
    cyc[1] = 1; new_beat(1);
    settle(); adv();
    settle(); cmp("ar_grant1", grant, 2'b10);
    rst_n = 0;
    #1;
    cmp("ar_grant", grant, 2'b00);
    cmp("ar_s_cyc", s_cyc, 1'b0);
    cmp("ar_s_stb", s_stb, 1'b0);
    model_reset();
    settle();
    cyc[0] = 1; new_beat(0);
    @(posedge clk);
    #2;
    rst_n = 1;
    settle(); adv();
    settle(); cmp("ar_tie_m0", grant, 2'b01); adv();

    // Ack arrives on the watchdog limit cycle
    do_reset();
    cyc[0] = 1; new_beat(0);
    settle(); adv();
    for (int k = 0; k < TMO - 1; k++) begin settle(); adv(); end
    s_ack = 1;
    settle(); cmp("lim_ack", ack[0], 1'b1); adv();
    s_ack = 0; new_beat(0);
    settle(); cmp("lim_no_err", err[0], 1'b0); cmp("lim_no_tmo", tmo_o, 1'b0);
    cmp("lim_grant", grant, 2'b01);
    n0 = 0;
    adv();
    for (int k = 0; k < TMO - 2; k++) begin
      settle();
      if (err[0]) n0++;
      adv();
    end
    cmp("lim_wdog_cleared", n0, 0);
    cyc = '0; stb = '0;
    settle(); adv();

    // Randomized traffic against the model
    do_reset();
    hang_left = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!cyc[i]) begin
          if ($urandom_range(3) == 0) begin cyc[i] = 1; new_beat(i); end
        end else if (exp_err[i]) begin
          cyc[i] = 0; stb[i] = 0;
        end else if (!stb[i] || exp_ack[i]) begin
          case ($urandom_range(3))
            0: begin cyc[i] = 0; stb[i] = 0; end
            1: stb[i] = 0;
            default: new_beat(i);
          endcase
        end
      end
      if (hang_left > 0) begin
        hang_left--;
        s_ack = 0;
      end else begin
        if ($urandom_range(15) == 0) hang_left = $urandom_range(12, 4);
        s_ack = 1'($urandom_range(1));
      end
      s_rdat = $urandom;
      tmo_clr = ($urandom_range(7) == 0);
      settle();
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
